// File: rtl/perf_monitor_fwd.sv
// Retirement performance monitor: event counters, end-of-test self-loop and hang detection.
// Optional longest-stall tracking is enabled with macro PERF_STALL_TRACK_EN.
module perf_monitor_fwd #(
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned HANG_LIMIT  = 1024,
    parameter int unsigned DONE_REPEAT = 4
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [31:0] i_pc_debug,
    input  logic        i_insn_vld,
    input  logic        i_ctrl,
    input  logic        i_mispred,
    input  logic        i_clr,
    input  logic [2:0]  i_rd_sel,
    output logic [31:0] o_rd_data,
    output logic        o_done,
    output logic        o_hang
);

    localparam int unsigned STALL_W = $clog2(HANG_LIMIT + 1);
    localparam int unsigned STRK_W  = $clog2(DONE_REPEAT + 1);
    localparam int unsigned RD_W    = (CNT_W > 32) ? CNT_W : 32;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2,
        S_HANG = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cyc_q, cyc_d;
    logic [CNT_W-1:0]   ret_q, ret_d;
    logic [CNT_W-1:0]   ctl_q, ctl_d;
    logic [CNT_W-1:0]   mis_q, mis_d;
    logic [31:0]        last_pc_q, last_pc_d;
    logic [STRK_W-1:0]  streak_q, streak_d;
    logic [STALL_W-1:0] stall_q, stall_d;
    logic               done_q, done_d;
    logic               hang_q, hang_d;
`ifdef PERF_STALL_TRACK_EN
    logic [STALL_W-1:0] max_stall_q, max_stall_d;
`endif

    logic counted;
    logic in_run;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

    // Zero-extend narrow counters, keep the low word of wide ones.
    function automatic logic [31:0] rd_cnt(input logic [CNT_W-1:0] v);
        logic [RD_W-1:0] w;
        w = RD_W'(v);
        return w[31:0];
    endfunction

    // Next-state and counter update; clear wins over any same-cycle retire.
    always_comb begin
        counted     = i_insn_vld && ((state_q == S_IDLE) || (state_q == S_RUN));
        in_run      = (state_q == S_RUN);
        state_d     = state_q;
        cyc_d       = cyc_q;
        ret_d       = ret_q;
        ctl_d       = ctl_q;
        mis_d       = mis_q;
        last_pc_d   = last_pc_q;
        streak_d    = streak_q;
        stall_d     = stall_q;
`ifdef PERF_STALL_TRACK_EN
        max_stall_d = max_stall_q;
`endif
        if (i_clr) begin
            state_d     = S_IDLE;
            cyc_d       = '0;
            ret_d       = '0;
            ctl_d       = '0;
            mis_d       = '0;
            last_pc_d   = '0;
            streak_d    = '0;
            stall_d     = '0;
`ifdef PERF_STALL_TRACK_EN
            max_stall_d = '0;
`endif
        end else begin
            if (counted) begin
                ret_d     = sat_inc(ret_q);
                last_pc_d = i_pc_debug;
                stall_d   = '0;
                if (i_ctrl) begin
                    ctl_d = sat_inc(ctl_q);
                end
                if (i_ctrl && i_mispred) begin
                    mis_d = sat_inc(mis_q);
                end
                if (i_pc_debug == last_pc_q) begin
                    streak_d = (streak_q == {STRK_W{1'b1}}) ? streak_q : streak_q + STRK_W'(1);
                end else begin
                    streak_d = STRK_W'(1);
                end
            end else if (in_run) begin
                stall_d = (stall_q == STALL_W'(HANG_LIMIT)) ? stall_q : stall_q + STALL_W'(1);
            end

            if (in_run || ((state_q == S_IDLE) && i_insn_vld)) begin
                cyc_d = sat_inc(cyc_q);
            end

`ifdef PERF_STALL_TRACK_EN
            if (in_run && (stall_d > max_stall_q)) begin
                max_stall_d = stall_d;
            end
`endif

            case (state_q)
                S_IDLE: begin
                    if (i_insn_vld) begin
                        state_d = S_RUN;
                    end
                end
                S_RUN: begin
                    if (counted && (streak_d == STRK_W'(DONE_REPEAT))) begin
                        state_d = S_DONE;
                    end else if (stall_d == STALL_W'(HANG_LIMIT)) begin
                        state_d = S_HANG;
                    end
                end
                default: state_d = state_q;
            endcase
        end
        done_d = (state_d == S_DONE);
        hang_d = (state_d == S_HANG);
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q     <= S_IDLE;
            cyc_q       <= '0;
            ret_q       <= '0;
            ctl_q       <= '0;
            mis_q       <= '0;
            last_pc_q   <= '0;
            streak_q    <= '0;
            stall_q     <= '0;
            done_q      <= 1'b0;
            hang_q      <= 1'b0;
`ifdef PERF_STALL_TRACK_EN
            max_stall_q <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cyc_q       <= cyc_d;
            ret_q       <= ret_d;
            ctl_q       <= ctl_d;
            mis_q       <= mis_d;
            last_pc_q   <= last_pc_d;
            streak_q    <= streak_d;
            stall_q     <= stall_d;
            done_q      <= done_d;
            hang_q      <= hang_d;
`ifdef PERF_STALL_TRACK_EN
            max_stall_q <= max_stall_d;
`endif
        end
    end

    assign o_done = done_q;
    assign o_hang = hang_q;

    // Register read mux.
    always_comb begin
        o_rd_data = '0;
        case (i_rd_sel)
            3'd0: o_rd_data = rd_cnt(cyc_q);
            3'd1: o_rd_data = rd_cnt(ret_q);
            3'd2: o_rd_data = rd_cnt(ctl_q);
            3'd3: o_rd_data = rd_cnt(mis_q);
            3'd4: o_rd_data = last_pc_q;
`ifdef PERF_STALL_TRACK_EN
            3'd5: o_rd_data = 32'(max_stall_q);
`else
            3'd5: o_rd_data = '0;
`endif
            3'd6: o_rd_data = {30'b0, state_q};
            default: o_rd_data = '0;
        endcase
    end

endmodule

// File: tb/tb_perf_monitor_fwd.sv
// Directed self-checking bench for perf_monitor_fwd: a 32-bit-counter instance and a
// 4-bit-counter instance driven by the same stimulus.
module tb_perf_monitor_fwd;

    logic        clk;
    logic        i_reset;
    logic [31:0] i_pc_debug;
    logic        i_insn_vld;
    logic        i_ctrl;
    logic        i_mispred;
    logic        i_clr;
    logic [2:0]  i_rd_sel;
    logic [31:0] rd_data;
    logic        done;
    logic        hang;
    logic [31:0] rd_data4;
    logic        done4;
    logic        hang4;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] exp_stall16;
    logic [31:0] exp_stall15;

    perf_monitor_fwd #(.CNT_W(32), .HANG_LIMIT(16), .DONE_REPEAT(4)) u_dut (
        .i_clk(clk), .i_reset(i_reset), .i_pc_debug(i_pc_debug), .i_insn_vld(i_insn_vld),
        .i_ctrl(i_ctrl), .i_mispred(i_mispred), .i_clr(i_clr), .i_rd_sel(i_rd_sel),
        .o_rd_data(rd_data), .o_done(done), .o_hang(hang)
    );

    perf_monitor_fwd #(.CNT_W(4), .HANG_LIMIT(16), .DONE_REPEAT(4)) u_dut4 (
        .i_clk(clk), .i_reset(i_reset), .i_pc_debug(i_pc_debug), .i_insn_vld(i_insn_vld),
        .i_ctrl(i_ctrl), .i_mispred(i_mispred), .i_clr(i_clr), .i_rd_sel(i_rd_sel),
        .o_rd_data(rd_data4), .o_done(done4), .o_hang(hang4)
    );

    initial clk = 1'b0;
    always #50 clk = ~clk;

    // One clock of stimulus; inputs drop back to idle just after the edge.
    task automatic step(input logic [31:0] pc, input logic vld, input logic ctrl,
                        input logic mis, input logic clr);
        @(negedge clk);
        i_pc_debug = pc;
        i_insn_vld = vld;
        i_ctrl     = ctrl;
        i_mispred  = mis;
        i_clr      = clr;
        @(posedge clk);
        #1;
        i_insn_vld = 1'b0;
        i_ctrl     = 1'b0;
        i_mispred  = 1'b0;
        i_clr      = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [2:0] sel, input logic [31:0] exp);
        i_rd_sel = sel;
        #1;
        n_tests++;
        assert (rd_data === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, rd_data, exp);
        end
    endtask

    task automatic chk4(input string tag, input logic [2:0] sel, input logic [31:0] exp);
        i_rd_sel = sel;
        #1;
        n_tests++;
        assert (rd_data4 === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, rd_data4, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    initial begin
`ifdef PERF_STALL_TRACK_EN
        exp_stall16 = 32'd16;
        exp_stall15 = 32'd15;
`else
        exp_stall16 = 32'd0;
        exp_stall15 = 32'd0;
`endif
        i_reset    = 1'b1;
        i_pc_debug = '0;
        i_insn_vld = 1'b0;
        i_ctrl     = 1'b0;
        i_mispred  = 1'b0;
        i_clr      = 1'b0;
        i_rd_sel   = '0;
        #20;

        // Reset values
        chk("rst_cycles", 3'd0, 32'd0);
        chk("rst_retired", 3'd1, 32'd0);
        chk("rst_lastpc", 3'd4, 32'd0);
        chk("rst_state", 3'd6, 32'd0);
        chk1("rst_done", done, 1'b0);
        chk1("rst_hang", hang, 1'b0);
        @(negedge clk);
        i_reset = 1'b0;

        // Three consecutive retires
        step(32'h0, 1, 0, 0, 0);
        step(32'h4, 1, 0, 0, 0);
        step(32'h8, 1, 0, 0, 0);
        chk("seq_state", 3'd6, 32'd1);
        chk("seq_retired", 3'd1, 32'd3);
        chk("seq_cycles", 3'd0, 32'd3);
        chk("seq_lastpc", 3'd4, 32'h8);
        chk4("seq_retired_w4", 3'd1, 32'd3);

        // Control / mispredict accounting; mispred without ctrl is ignored
        step(32'h10, 1, 1, 0, 0);
        step(32'h14, 1, 1, 1, 0);
        step(32'h18, 1, 1, 0, 0);
        step(32'h1c, 1, 1, 1, 0);
        step(32'h20, 1, 1, 0, 0);
        step(32'h24, 1, 0, 1, 0);
        chk("br_control", 3'd2, 32'd5);
        chk("br_mispred", 3'd3, 32'd2);
        chk("br_retired", 3'd1, 32'd9);
        chk("br_cycles", 3'd0, 32'd9);

        // Same-PC self loop ends the test on the fourth retire
        step(32'h40, 1, 0, 0, 0);
        step(32'h40, 1, 0, 0, 0);
        step(32'h40, 1, 0, 0, 0);
        chk("loop3_state", 3'd6, 32'd1);
        chk1("loop3_done", done, 1'b0);
        step(32'h40, 1, 0, 0, 0);
        chk1("loop4_done", done, 1'b1);
        chk1("loop4_hang", hang, 1'b0);
        chk("loop4_state", 3'd6, 32'd2);
        chk("loop4_retired", 3'd1, 32'd13);
        step(32'h50, 1, 1, 1, 0);
        step(32'h50, 1, 0, 0, 0);
        step(32'h0, 0, 0, 0, 0);
        chk("done_frz_retired", 3'd1, 32'd13);
        chk("done_frz_cycles", 3'd0, 32'd13);
        chk("done_frz_control", 3'd2, 32'd5);
        chk("done_frz_lastpc", 3'd4, 32'h40);
        chk1("done_sticky", done, 1'b1);

        // Clear leaves DONE; then hang after HANG_LIMIT idle cycles
        step(32'h0, 0, 0, 0, 1);
        chk("clr_state", 3'd6, 32'd0);
        chk("clr_retired", 3'd1, 32'd0);
        chk1("clr_done", done, 1'b0);
        step(32'h100, 1, 0, 0, 0);
        for (int i = 0; i < 15; i++) step(32'h0, 0, 0, 0, 0);
        chk1("stall15_hang", hang, 1'b0);
        chk("stall15_cycles", 3'd0, 32'd16);
        chk("stall15_max", 3'd5, exp_stall15);
        step(32'h0, 0, 0, 0, 0);
        chk1("stall16_hang", hang, 1'b1);
        chk("stall16_state", 3'd6, 32'd3);
        chk("stall16_max", 3'd5, exp_stall16);
        chk("stall16_cycles", 3'd0, 32'd17);
        step(32'h0, 0, 0, 0, 0);
        step(32'h104, 1, 0, 0, 0);
        chk("hang_frz_cycles", 3'd0, 32'd17);
        chk("hang_frz_retired", 3'd1, 32'd1);
        chk1("hang_sticky", hang, 1'b1);

        // Clear beats a simultaneous retire
        step(32'h0, 0, 0, 0, 1);
        step(32'h200, 1, 1, 1, 0);
        step(32'h204, 1, 1, 0, 0);
        chk("pre_clr_retired", 3'd1, 32'd2);
        step(32'h208, 1, 1, 1, 1);
        chk("clrret_cycles", 3'd0, 32'd0);
        chk("clrret_retired", 3'd1, 32'd0);
        chk("clrret_control", 3'd2, 32'd0);
        chk("clrret_mispred", 3'd3, 32'd0);
        chk("clrret_lastpc", 3'd4, 32'd0);
        chk("clrret_max", 3'd5, 32'd0);
        chk("clrret_state", 3'd6, 32'd0);
        step(32'h20c, 1, 0, 0, 0);
        chk("after_clr_retired", 3'd1, 32'd1);
        chk("after_clr_lastpc", 3'd4, 32'h20c);

        // Saturation of a 4-bit counter
        step(32'h0, 0, 0, 0, 1);
        for (int i = 0; i < 20; i++) step(32'h1000 + 32'(i * 4), 1, 0, 0, 0);
        chk4("sat_retired_w4", 3'd1, 32'd15);
        chk4("sat_cycles_w4", 3'd0, 32'd15);
        chk("sat_retired_w32", 3'd1, 32'd20);
        chk("sel7_zero", 3'd7, 32'd0);

        // Asynchronous reset mid-run discards everything
        @(negedge clk);
        #10;
        i_reset = 1'b1;
        chk("arst_retired", 3'd1, 32'd0);
        chk("arst_cycles", 3'd0, 32'd0);
        chk("arst_state", 3'd6, 32'd0);
        @(negedge clk);
        i_reset = 1'b0;
        step(32'h3000, 1, 0, 0, 0);
        chk("arst_resume_retired", 3'd1, 32'd1);
        chk("arst_resume_cycles", 3'd0, 32'd1);
        chk("arst_resume_state", 3'd6, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
